// File: rtl/audio_seq_player_pkg.sv
// audio_pkg: shared types and constant tables for the tune sequencer.
//   NOTE_W_DEF      default note code width
//   state_e         sequencer FSM states
//   NOTE_*          note codes presented to the audio datapath
//   tune_note(t,i)  note i of tune t (0 outside the tune)
//   tune_len(t)     number of notes in tune t (0 = empty tune)
package audio_pkg;

    localparam int NOTE_W_DEF = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_GAP,
        ST_DONE
    } state_e;

    localparam logic [NOTE_W_DEF-1:0] NOTE_C  = 7'h10;
    localparam logic [NOTE_W_DEF-1:0] NOTE_D  = 7'h11;
    localparam logic [NOTE_W_DEF-1:0] NOTE_E  = 7'h12;
    localparam logic [NOTE_W_DEF-1:0] NOTE_F  = 7'h13;
    localparam logic [NOTE_W_DEF-1:0] NOTE_G  = 7'h14;
    localparam logic [NOTE_W_DEF-1:0] NOTE_A  = 7'h15;
    localparam logic [NOTE_W_DEF-1:0] NOTE_B  = 7'h16;

    function automatic logic [NOTE_W_DEF-1:0] tune_note(int unsigned t, int unsigned i);
        logic [NOTE_W_DEF-1:0] n;
        n = '0;
        case (t)
            0: case (i)
                0: n = NOTE_C;
                1: n = NOTE_D;
                2: n = NOTE_C;
                3: n = NOTE_G;
                4: n = NOTE_C;
                5: n = NOTE_D;
                6: n = NOTE_A;
                7: n = NOTE_G;
                default: n = '0;
            endcase
            1: case (i)
                0: n = NOTE_E;
                1: n = NOTE_F;
                default: n = '0;
            endcase
            2: case (i)
                0: n = NOTE_G;
                1: n = NOTE_A;
                2: n = NOTE_B;
                default: n = '0;
            endcase
            default: n = '0;
        endcase
        return n;
    endfunction

    function automatic int unsigned tune_len(int unsigned t);
        case (t)
            0:       return 8;
            1:       return 2;
            2:       return 3;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/audio_seq_player_if.sv
// audio_seq_player_if: game-control / audio-datapath bundle of the tune sequencer.
//   start, tune_sel, abort, note_done (and loop with AUDIO_SEQ_LOOP_EN): into player
//   enable_audio, note, busy, done: out of player
//   master = controller side, slave = player side.
interface audio_seq_player_if #(
    parameter int NOTE_W = 7,
    parameter int SEL_W  = 2
) ();
    logic              start;
    logic [SEL_W-1:0]  tune_sel;
    logic              abort;
    logic              note_done;
`ifdef AUDIO_SEQ_LOOP_EN
    logic              loop;
`endif
    logic              enable_audio;
    logic [NOTE_W-1:0] note;
    logic              busy;
    logic              done;

    modport master (
        output start, tune_sel, abort, note_done,
`ifdef AUDIO_SEQ_LOOP_EN
        output loop,
`endif
        input  enable_audio, note, busy, done
    );

    modport slave (
        input  start, tune_sel, abort, note_done,
`ifdef AUDIO_SEQ_LOOP_EN
        input  loop,
`endif
        output enable_audio, note, busy, done
    );
endinterface

// File: rtl/audio_seq_player_tune_rom.sv
// audio_tune_rom: combinational tune table lookup.
//   tune, idx -> note (code at that position), len (notes in the tune)
module audio_tune_rom
    import audio_pkg::*;
#(
    parameter int NOTE_W = NOTE_W_DEF,
    parameter int SEL_W  = 2,
    parameter int IDX_W  = 4,
    parameter int LEN_W  = 5
) (
    input  logic [SEL_W-1:0]  tune,
    input  logic [IDX_W-1:0]  idx,
    output logic [NOTE_W-1:0] note,
    output logic [LEN_W-1:0]  len
);
    always_comb begin
        note = NOTE_W'(tune_note(int'(tune), int'(idx)));
        len  = LEN_W'(tune_len(int'(tune)));
    end
endmodule

// File: rtl/audio_seq_player.sv
// audio_seq_player: plays one of NUM_TUNES stored note sequences.
//   clk, resetn : clock, asynchronous active-low reset
//   bus (slave) : start/tune_sel/abort/note_done in; enable_audio/note/busy/done out
// Each note is held until note_done, followed by GAP_CYCLES silent cycles.
// Optional feature macro AUDIO_SEQ_LOOP_EN: adds bus.loop, latched with tune_sel;
// a looping tune restarts at note 0 instead of finishing, until abort.
module audio_seq_player
    import audio_pkg::*;
#(
    parameter int NOTE_W     = NOTE_W_DEF,
    parameter int MAX_NOTES  = 16,
    parameter int NUM_TUNES  = 4,
    parameter int GAP_CYCLES = 1
) (
    input logic               clk,
    input logic               resetn,
    audio_seq_player_if.slave bus
);
    localparam int SEL_W = (NUM_TUNES > 1) ? $clog2(NUM_TUNES) : 1;
    localparam int IDX_W = (MAX_NOTES > 1) ? $clog2(MAX_NOTES) : 1;
    localparam int LEN_W = $clog2(MAX_NOTES + 1);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [SEL_W-1:0]   tune_q, tune_d;
`ifdef AUDIO_SEQ_LOOP_EN
    logic               loop_q, loop_d;
`else
    localparam logic    loop_q = 1'b0;
`endif

    logic [SEL_W-1:0]   sel_map;
    logic [SEL_W-1:0]   rom_tune;
    logic [NOTE_W-1:0]  rom_note;
    logic [LEN_W-1:0]   rom_len;
    logic               last;

    // In IDLE the ROM looks at the incoming selection so the empty-tune
    // decision is made on the accepting edge; otherwise at the latched tune.
    always_comb begin
        sel_map  = (int'(bus.tune_sel) >= NUM_TUNES) ? '0 : bus.tune_sel;
        rom_tune = (state_q == ST_IDLE) ? sel_map : tune_q;
        last     = (int'(idx_q) + 1 >= int'(rom_len));
    end

    audio_tune_rom #(
        .NOTE_W (NOTE_W),
        .SEL_W  (SEL_W),
        .IDX_W  (IDX_W),
        .LEN_W  (LEN_W)
    ) u_rom (
        .tune (rom_tune),
        .idx  (idx_q),
        .note (rom_note),
        .len  (rom_len)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        gap_cnt_d = gap_cnt_q;
        tune_d    = tune_q;
`ifdef AUDIO_SEQ_LOOP_EN
        loop_d    = loop_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    tune_d    = sel_map;
`ifdef AUDIO_SEQ_LOOP_EN
                    loop_d    = bus.loop;
`endif
                    idx_d     = '0;
                    gap_cnt_d = '0;
                    state_d   = (rom_len != '0) ? ST_PLAY : ST_DONE;
                end
            end
            ST_PLAY: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else if (bus.note_done) begin
                    if (last && !loop_q) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = last ? '0 : idx_q + 1'b1;
                        if (GAP_CYCLES == 0) begin
                            state_d = ST_PLAY;
                        end else begin
                            state_d   = ST_GAP;
                            gap_cnt_d = '0;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (bus.abort) begin
                    state_d   = ST_IDLE;
                    idx_d     = '0;
                    gap_cnt_d = '0;
                end else if (int'(gap_cnt_q) >= GAP_CYCLES - 1) begin
                    state_d   = ST_PLAY;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (bus.abort || !bus.start) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            gap_cnt_q <= '0;
            tune_q    <= '0;
`ifdef AUDIO_SEQ_LOOP_EN
            loop_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            gap_cnt_q <= gap_cnt_d;
            tune_q    <= tune_d;
`ifdef AUDIO_SEQ_LOOP_EN
            loop_q    <= loop_d;
`endif
        end
    end

    // Moore outputs; done stays low for a looping tune even if it sits in DONE.
    always_comb begin
        bus.enable_audio = (state_q == ST_PLAY);
        bus.note         = (state_q == ST_PLAY) ? rom_note : '0;
        bus.busy         = (state_q == ST_PLAY) || (state_q == ST_GAP);
        bus.done         = (state_q == ST_DONE) && !loop_q;
    end
endmodule
